// File: rtl/boot_pkg.sv
// boot_pkg: shared types and constants for the boot image loader.
//   boot_state_e    - loader FSM states
//   BOOT_*_BYTES    - byte counts of the length, word and checksum fields
package boot_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN    = 3'd1,
        ST_DATA   = 3'd2,
        ST_WRITE  = 3'd3,
        ST_CSUM   = 3'd4,
        ST_VERIFY = 3'd5,
        ST_DONE   = 3'd6,
        ST_ERROR  = 3'd7
    } boot_state_e;

    localparam int BOOT_LEN_BYTES  = 2;
    localparam int BOOT_CSUM_BYTES = 4;
    localparam int BOOT_WORD_BYTES = 4;

endpackage

// File: rtl/boot_word_assembler.sv
// boot_word_assembler: little-endian byte-to-word assembler.
//   clk_i, rst_ni - clock, async active-low reset
//   clr_i         - clears index and word (wins over en_i)
//   en_i, byte_i  - insert byte_i at the current index
//   word_o        - registered word
//   word_nxt_o    - word including the byte being inserted this cycle
//   idx_o         - current byte index
//   full_o        - pulse when the 4th byte is inserted
module boot_word_assembler (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clr_i,
    input  logic        en_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic [31:0] word_nxt_o,
    output logic [1:0]  idx_o,
    output logic        full_o
);

    logic [31:0] word_q;
    logic [1:0]  idx_q;

    always_comb begin
        word_nxt_o = word_q;
        word_nxt_o[{idx_q, 3'b000} +: 8] = byte_i;
    end

    assign full_o = en_i && (idx_q == 2'd3);
    assign word_o = word_q;
    assign idx_o  = idx_q;

    // The 2-bit index wraps on its own after the 4th byte, so consecutive
    // payload words need no explicit clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            word_q <= '0;
            idx_q  <= '0;
        end else if (clr_i) begin
            word_q <= '0;
            idx_q  <= '0;
        end else if (en_i) begin
            word_q <= word_nxt_o;
            idx_q  <= idx_q + 2'd1;
        end
    end

endmodule

// File: rtl/boot_loader.sv
// boot_loader: parses a length-prefixed little-endian boot stream, writes
// the payload words to SRAM from address 0 and checks a trailing 32-bit sum.
//   boot_clk, boot_rst_n            - clock, async active-low reset
//   boot_start                      - start pulse (honoured in IDLE/DONE/ERROR)
//   boot_byte_i/valid/ready         - byte stream handshake
//   boot_sram_addr/wdata/cs/we/oe   - SRAM port
//   boot_sram_rdata/rvalid          - SRAM read return (readback only)
//   boot_busy/done/error/words      - status
// Optional feature: define BOOT_READBACK_EN to re-read and re-sum the image
// after a checksum match.
module boot_loader
    import boot_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 13,
    parameter int RAM_DEPTH  = 8192
) (
    input  logic                  boot_clk,
    input  logic                  boot_rst_n,
    input  logic                  boot_start,
    input  logic [7:0]            boot_byte_i,
    input  logic                  boot_byte_valid,
    output logic                  boot_byte_ready,
    output logic [ADDR_WIDTH-1:0] boot_sram_addr,
    output logic [DATA_WIDTH-1:0] boot_sram_wdata,
    output logic                  boot_sram_cs,
    output logic                  boot_sram_we,
    output logic                  boot_sram_oe,
    input  logic [DATA_WIDTH-1:0] boot_sram_rdata,
    input  logic                  boot_sram_rvalid,
    output logic                  boot_busy,
    output logic                  boot_done,
    output logic                  boot_error,
    output logic [ADDR_WIDTH:0]   boot_words
);

    boot_state_e         state_q, state_d;
    logic [ADDR_WIDTH:0] n_q, words_q, words_inc;
    logic [31:0]         sum_q;
    logic                done_q, err_q;

    logic        accept, start_ok, len_last, len_bad, csum_last, csum_ok;
    logic        asm_clr, asm_full;
    logic [31:0] asm_word, asm_word_nxt;
    logic [1:0]  asm_idx;
    logic [15:0] len_raw;

    assign accept    = boot_byte_valid && boot_byte_ready;
    assign start_ok  = boot_start && (state_q inside {ST_IDLE, ST_DONE, ST_ERROR});
    assign len_raw   = asm_word_nxt[15:0];
    assign len_last  = accept && (state_q == ST_LEN) && (asm_idx == 2'(BOOT_LEN_BYTES - 1));
    assign len_bad   = (len_raw == 16'd0) || (32'(len_raw) > RAM_DEPTH);
    assign csum_last = accept && (state_q == ST_CSUM) && asm_full;
    assign csum_ok   = (asm_word_nxt == sum_q);
    assign words_inc = words_q + 1'b1;
    // Length field only uses two byte lanes; restart at lane 0 for payload.
    assign asm_clr   = start_ok || len_last;

    boot_word_assembler u_asm (
        .clk_i      (boot_clk),
        .rst_ni     (boot_rst_n),
        .clr_i      (asm_clr),
        .en_i       (accept),
        .byte_i     (boot_byte_i),
        .word_o     (asm_word),
        .word_nxt_o (asm_word_nxt),
        .idx_o      (asm_idx),
        .full_o     (asm_full)
    );

`ifdef BOOT_READBACK_EN
    logic [ADDR_WIDTH:0] vcnt_q, vaddr;
    logic [31:0]         csum_q, rsum_q, rsum_nxt;
    logic                vfy_last;

    // Address steps 0..N-1 then holds N-1 for one extra cycle so the
    // registered read of the last word lands inside VERIFY.
    assign vaddr    = (vcnt_q < n_q) ? vcnt_q : (n_q - 1'b1);
    assign rsum_nxt = rsum_q + (boot_sram_rvalid ? 32'(boot_sram_rdata) : 32'd0);
    assign vfy_last = (state_q == ST_VERIFY) && (vcnt_q == n_q);
`else
    logic unused_rb;
    assign unused_rb = ^{boot_sram_rdata, boot_sram_rvalid};
`endif

    // State register
    always_ff @(posedge boot_clk or negedge boot_rst_n) begin
        if (!boot_rst_n) state_q <= ST_IDLE;
        else             state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: if (boot_start) state_d = ST_LEN;
            ST_LEN:   if (len_last) state_d = len_bad ? ST_ERROR : ST_DATA;
            ST_DATA:  if (asm_full) state_d = ST_WRITE;
            ST_WRITE: state_d = (words_inc == n_q) ? ST_CSUM : ST_DATA;
            ST_CSUM: begin
                if (csum_last) begin
`ifdef BOOT_READBACK_EN
                    state_d = csum_ok ? ST_VERIFY : ST_ERROR;
`else
                    state_d = csum_ok ? ST_DONE : ST_ERROR;
`endif
                end
            end
`ifdef BOOT_READBACK_EN
            ST_VERIFY: if (vfy_last) state_d = (rsum_nxt == csum_q) ? ST_DONE : ST_ERROR;
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        boot_byte_ready = 1'b0;
        boot_busy       = 1'b0;
        boot_sram_cs    = 1'b0;
        boot_sram_we    = 1'b0;
        boot_sram_oe    = 1'b0;
        boot_sram_addr  = '0;
        boot_sram_wdata = '0;
        case (state_q)
            ST_LEN, ST_DATA, ST_CSUM: begin
                boot_byte_ready = 1'b1;
                boot_busy       = 1'b1;
            end
            ST_WRITE: begin
                boot_busy       = 1'b1;
                boot_sram_cs    = 1'b1;
                boot_sram_we    = 1'b1;
                boot_sram_addr  = words_q[ADDR_WIDTH-1:0];
                boot_sram_wdata = DATA_WIDTH'(asm_word);
            end
`ifdef BOOT_READBACK_EN
            ST_VERIFY: begin
                boot_busy      = 1'b1;
                boot_sram_cs   = 1'b1;
                boot_sram_oe   = 1'b1;
                boot_sram_addr = vaddr[ADDR_WIDTH-1:0];
            end
`endif
            default: ;
        endcase
    end

    // Datapath: counters, running sum, sticky flags
    always_ff @(posedge boot_clk or negedge boot_rst_n) begin
        if (!boot_rst_n) begin
            n_q     <= '0;
            words_q <= '0;
            sum_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (start_ok) begin
                words_q <= '0;
                sum_q   <= '0;
                done_q  <= 1'b0;
                err_q   <= 1'b0;
            end
            if (len_last) begin
                if (len_bad) err_q <= 1'b1;
                else         n_q   <= len_raw[ADDR_WIDTH:0];
            end
            if (state_q == ST_WRITE) begin
                words_q <= words_inc;
                sum_q   <= sum_q + asm_word;   // wraps mod 2^32
            end
            if (csum_last) begin
`ifdef BOOT_READBACK_EN
                if (!csum_ok) err_q <= 1'b1;
`else
                if (csum_ok) done_q <= 1'b1;
                else         err_q  <= 1'b1;
`endif
            end
`ifdef BOOT_READBACK_EN
            if (vfy_last) begin
                if (rsum_nxt == csum_q) done_q <= 1'b1;
                else                    err_q  <= 1'b1;
            end
`endif
        end
    end

`ifdef BOOT_READBACK_EN
    always_ff @(posedge boot_clk or negedge boot_rst_n) begin
        if (!boot_rst_n) begin
            vcnt_q <= '0;
            csum_q <= '0;
            rsum_q <= '0;
        end else if (csum_last) begin
            vcnt_q <= '0;
            csum_q <= asm_word_nxt;
            rsum_q <= '0;
        end else if (state_q == ST_VERIFY) begin
            vcnt_q <= vcnt_q + 1'b1;
            rsum_q <= rsum_nxt;
        end
    end
`endif

    assign boot_done  = done_q;
    assign boot_error = err_q;
    assign boot_words = words_q;

endmodule

// File: tb/tb_boot_loader.sv
// tb_boot_loader: randomized self-checking bench for boot_loader with an
// SRAM model and a stream-level reference model.
module tb_boot_loader;

    logic        boot_clk = 1'b0;
    logic        boot_rst_n;
    logic        boot_start;
    logic [7:0]  boot_byte_i;
    logic        boot_byte_valid;
    logic        boot_byte_ready;
    logic [12:0] boot_sram_addr;
    logic [31:0] boot_sram_wdata;
    logic        boot_sram_cs, boot_sram_we, boot_sram_oe;
    logic [31:0] boot_sram_rdata;
    logic        boot_sram_rvalid;
    logic        boot_busy, boot_done, boot_error;
    logic [13:0] boot_words;

    boot_loader dut (
        .boot_clk         (boot_clk),
        .boot_rst_n       (boot_rst_n),
        .boot_start       (boot_start),
        .boot_byte_i      (boot_byte_i),
        .boot_byte_valid  (boot_byte_valid),
        .boot_byte_ready  (boot_byte_ready),
        .boot_sram_addr   (boot_sram_addr),
        .boot_sram_wdata  (boot_sram_wdata),
        .boot_sram_cs     (boot_sram_cs),
        .boot_sram_we     (boot_sram_we),
        .boot_sram_oe     (boot_sram_oe),
        .boot_sram_rdata  (boot_sram_rdata),
        .boot_sram_rvalid (boot_sram_rvalid),
        .boot_busy        (boot_busy),
        .boot_done        (boot_done),
        .boot_error       (boot_error),
        .boot_words       (boot_words)
    );

    always #5 boot_clk = ~boot_clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // SRAM model and write log
    logic [31:0] mem [0:8191];
    logic [44:0] wr_q[$];
    int          cs_cnt;
    logic        corrupt_on = 1'b0;
    logic [12:0] corrupt_idx = '0;

    always @(negedge boot_clk) begin
        if (boot_rst_n) begin
            // ready only while accepting bytes: busy and not touching SRAM
            chk("ready", boot_byte_ready, boot_busy && !boot_sram_cs);
            if (boot_sram_cs) cs_cnt++;
            if (boot_sram_we) begin
                chk("wr_ctl", {boot_sram_cs, boot_sram_oe}, 2'b10);
                wr_q.push_back({boot_sram_addr, boot_sram_wdata});
                mem[boot_sram_addr] = boot_sram_wdata;
            end
        end
    end

    always @(posedge boot_clk) begin
        boot_sram_rvalid <= boot_sram_cs && boot_sram_oe && !boot_sram_we;
        boot_sram_rdata  <= mem[boot_sram_addr] ^
                            ((corrupt_on && boot_sram_addr == corrupt_idx) ? 32'h1 : 32'h0);
    end

    // Stream driver: all tasks start and end just after a falling edge.
    logic [7:0]  tx_q[$];
    logic [31:0] exp_w[$];

    task automatic send_all(input int gap_max);
        for (int i = 0; i < tx_q.size(); i++) begin
            int  g;
            int  cyc;
            logic acc;
            g = (gap_max == 0) ? 0 : $urandom_range(gap_max, 0);
            boot_byte_valid = 1'b0;
            boot_byte_i     = 8'($urandom);
            repeat (g) @(negedge boot_clk);
            boot_byte_valid = 1'b1;
            boot_byte_i     = tx_q[i];
            acc = 1'b0;
            cyc = 0;
            while (!acc && cyc < 200) begin
                acc = boot_byte_ready;
                @(negedge boot_clk);
                cyc++;
            end
            if (!acc) begin
                chk("accept_timeout", 0, 1);
                boot_byte_valid = 1'b0;
                return;
            end
        end
        boot_byte_valid = 1'b0;
    endtask

    task automatic pulse_start(input string tag);
        wr_q.delete();
        cs_cnt = 0;
        boot_start = 1'b1;
        @(negedge boot_clk);
        boot_start = 1'b0;
        chk({tag, "_start_busy"}, boot_busy, 1'b1);
        chk({tag, "_start_clr"}, {boot_done, boot_error, boot_words}, 16'h0);
    endtask

    // Reference: builds the stream for (n, exp_w, csum) and predicts outcome.
    task automatic run_load(input logic [15:0] n, input logic [31:0] csum,
                            input bit corrupt, input int gap_max, input string tag);
        bit          len_bad, ok;
        logic [31:0] s;
        int          cnt;
        len_bad = (n == 0) || (n > 8192);
        s = 32'h0;
        tx_q.delete();
        tx_q.push_back(n[7:0]);
        tx_q.push_back(n[15:8]);
        if (!len_bad) begin
            foreach (exp_w[i]) begin
                s = s + exp_w[i];
                for (int b = 0; b < 4; b++) tx_q.push_back(8'(exp_w[i] >> (8 * b)));
            end
            for (int b = 0; b < 4; b++) tx_q.push_back(8'(csum >> (8 * b)));
        end
        ok = !len_bad && (s == csum);
        corrupt_on  = corrupt;
        corrupt_idx = 13'(n - 16'd1);
        pulse_start(tag);
        send_all(gap_max);
`ifdef BOOT_READBACK_EN
        if (ok) begin
            cnt = 0;
            while (boot_busy && cnt < int'(n) + 10) begin
                cnt++;
                @(negedge boot_clk);
            end
            chk({tag, "_verify_cycles"}, cnt, int'(n) + 1);
        end
`else
        cnt = 0;
`endif
        chk({tag, "_done"},  boot_done,  ok && !corrupt);
        chk({tag, "_error"}, boot_error, !(ok && !corrupt));
        chk({tag, "_words"}, boot_words, len_bad ? 14'd0 : 14'(n));
        chk({tag, "_idle"},  {boot_busy, boot_byte_ready}, 2'b00);
        chk({tag, "_nwr"},   wr_q.size(), len_bad ? 0 : int'(n));
        if (len_bad) chk({tag, "_no_cs"}, cs_cnt, 0);
        for (int i = 0; i < wr_q.size() && i < exp_w.size(); i++)
            chk($sformatf("%s_wr%0d", tag, i), wr_q[i], {13'(i), exp_w[i]});
        corrupt_on = 1'b0;
    endtask

    function automatic logic [31:0] sum_w();
        logic [31:0] s = 32'h0;
        foreach (exp_w[i]) s = s + exp_w[i];
        return s;
    endfunction

    task automatic rand_words(input int n);
        exp_w.delete();
        for (int i = 0; i < n; i++) exp_w.push_back($urandom);
    endtask

    initial begin
        boot_rst_n      = 1'b0;
        boot_start      = 1'b0;
        boot_byte_i     = 8'h0;
        boot_byte_valid = 1'b0;
        cs_cnt          = 0;
        repeat (3) @(negedge boot_clk);
        chk("rst_out", {boot_busy, boot_done, boot_error, boot_byte_ready, boot_sram_cs,
                        boot_sram_we, boot_sram_oe, boot_words, boot_sram_addr, boot_sram_wdata}, 0);
        boot_rst_n = 1'b1;
        @(negedge boot_clk);
        chk("post_rst", {boot_busy, boot_done, boot_error, boot_words}, 0);

        // N=1 basic
        exp_w = '{32'h12345678};
        run_load(16'd1, 32'h12345678, 1'b0, 0, "n1");
        // N=2, sum wraps
        exp_w = '{32'hFFFFFFFF, 32'h00000002};
        run_load(16'd2, 32'h00000001, 1'b0, 1, "wrap");
        // illegal lengths
        exp_w.delete();
        run_load(16'd0, 32'h0, 1'b0, 0, "len0");
        run_load(16'h2001, 32'h0, 1'b0, 2, "len8193");
        // N=2 wrong checksum
        rand_words(2);
        run_load(16'd2, sum_w() ^ 32'h0000_0100, 1'b0, 1, "badsum");
        // valid held continuously
        rand_words(5);
        run_load(16'd5, sum_w(), 1'b0, 0, "burst");
        // randomized loads
        for (int t = 0; t < 8; t++) begin
            int n;
            n = $urandom_range(6, 1);
            rand_words(n);
            run_load(16'(n), ($urandom_range(2, 0) == 0) ? sum_w() + 32'd7 : sum_w(),
                     1'b0, $urandom_range(3, 0), $sformatf("rnd%0d", t));
        end

        // reset mid-DATA
        rand_words(4);
        tx_q = '{8'h04, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        pulse_start("midrst");
        send_all(0);
        boot_rst_n = 1'b0;
        #1;
        chk("midrst_out", {boot_busy, boot_done, boot_error, boot_byte_ready, boot_sram_cs,
                           boot_sram_we, boot_sram_oe, boot_words, boot_sram_addr, boot_sram_wdata}, 0);
        @(negedge boot_clk);
        @(negedge boot_clk);
        boot_rst_n = 1'b1;
        @(negedge boot_clk);
        rand_words(3);
        run_load(16'd3, sum_w(), 1'b0, 1, "afterrst");

`ifdef BOOT_READBACK_EN
        rand_words(4);
        run_load(16'd4, sum_w(), 1'b1, 1, "corrupt");
        rand_words(3);
        run_load(16'd3, sum_w(), 1'b0, 0, "rb_ok");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=1 exp=0");
        $fatal(1);
    end

endmodule
